// File: rtl/sc_spi_burst_pkg.sv
// sc_spi_burst_pkg: shared constants for the SPI burst controller.
// Holds the FSM state encoding and the WCNT decode (0 means 256 words).
package sc_spi_burst_pkg;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_EXEC  = 3'd2;
   localparam logic [2:0] ST_TRANS = 3'd3;
   localparam logic [2:0] ST_END   = 3'd4;

   // Word count represented by WCNT == 0
   localparam logic [8:0] WCNT_ZERO_WORDS = 9'd256;

   // Expand the 8-bit WCNT field into a 9-bit word count
   function automatic logic [8:0] wcnt_decode(input logic [7:0] wcnt);
      return (wcnt == 8'd0) ? WCNT_ZERO_WORDS : {1'b0, wcnt};
   endfunction

endpackage

// File: rtl/sc_spi_sync_fifo.sv
// sc_spi_sync_fifo: single-clock first-word-fall-through FIFO with level.
// Push while full and pop while empty are ignored; rdata reads 0 when empty.
// clr empties the FIFO in one cycle without touching the storage.
module sc_spi_sync_fifo
   import sc_spi_burst_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          clr,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          empty,
   output logic          full,
   output logic [LW-1:0] level
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LW'(DEPTH));
   assign level   = count;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!rstb || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + LW'(do_push) - LW'(do_pop);
      end
   end

   // Storage write; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sc_spi_burst_ctrl.sv
// sc_spi_burst_ctrl: feeds an SPI shift engine from a TX FIFO and collects
// its received words into an RX FIFO for bursts of 1..256 words.
// Optional feature: define SC_SPI_BURST_ABORT_EN to add the ABORT input.
// dbg_state exposes the FSM state for observation.
module sc_spi_burst_ctrl
   import sc_spi_burst_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   parameter int NCS   = 4,
   localparam int CSW  = (NCS > 1) ? $clog2(NCS) : 1,
   localparam int LW   = $clog2(DEPTH) + 1
) (
   input  logic           SYSCLK,
   input  logic           SYSRSTB,
   input  logic           START,
   input  logic [7:0]     WCNT,
   input  logic [CSW-1:0] CSSEL,
   input  logic           TXWE,
   input  logic [DW-1:0]  TXWDATA,
   output logic           TXFULL,
   output logic [LW-1:0]  TXLEVEL,
   input  logic           RXRE,
   output logic [DW-1:0]  RXRDATA,
   output logic           RXEMPTY,
   output logic [LW-1:0]  RXLEVEL,
   output logic           BUSY,
   output logic           DONE,
   output logic           TXUNDER,
   output logic           RXOVER,
   input  logic           ERRCLR,
   output logic           SPC_SPISTART,
   output logic           SPC_LAST,
   output logic [NCS-1:0] SPC_CSSEL,
   output logic [DW-1:0]  SPC_TXDATA,
   input  logic           SPC_SPIBUSY,
   input  logic           SPC_TXDETECT,
   input  logic           SPC_RXVALID,
   input  logic [DW-1:0]  SPC_RXDATA,
`ifdef SC_SPI_BURST_ABORT_EN
   input  logic           ABORT,
`endif
   output logic [2:0]     dbg_state
);

   logic [2:0]     state;
   logic [8:0]     tx_rem;
   logic [8:0]     rx_rem;
   logic           active;
   logic           stopped;
   logic           tx_flush;
   logic           tx_pop;
   logic           tx_empty;
   logic [DW-1:0]  tx_head;
   logic           rx_evt;
   logic           rx_full;
   logic [NCS-1:0] cs_onehot;

   assign dbg_state = state;
   assign active    = (state == ST_EXEC) || (state == ST_TRANS);
   assign SPC_LAST  = active && ((tx_rem == 9'd0) || stopped);

   // SETUP always loads the first word; later words are loaded as the engine
   // consumes the current one, until the burst count is exhausted.
   assign tx_pop = (state == ST_SETUP) ||
                   ((state == ST_TRANS) && SPC_TXDETECT && (tx_rem != 9'd0) && !stopped);

   // Every received word counts against the burst, stored or dropped
   assign rx_evt = active && SPC_RXVALID && (rx_rem != 9'd0);

`ifdef SC_SPI_BURST_ABORT_EN
   logic abort_hold;

   // Remember an abort until the burst has wound down through END
   always_ff @(posedge SYSCLK) begin
      if (!SYSRSTB)               abort_hold <= 1'b0;
      else if (state == ST_END)   abort_hold <= 1'b0;
      else if (ABORT && active)   abort_hold <= 1'b1;
   end

   assign stopped  = abort_hold || (ABORT && active);
   assign tx_flush = (state == ST_END) && abort_hold;
`else
   assign stopped  = 1'b0;
   assign tx_flush = 1'b0;
`endif

   // Chip-select index to one-hot; out-of-range indices select nothing
   always_comb begin
      cs_onehot = '0;
      for (int i = 0; i < NCS; i++) cs_onehot[i] = (CSSEL == CSW'(i));
   end

   // Burst sequencer and engine-facing registers
   always_ff @(posedge SYSCLK) begin
      if (!SYSRSTB) begin
         state        <= ST_IDLE;
         tx_rem       <= '0;
         rx_rem       <= '0;
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
         SPC_SPISTART <= 1'b0;
         SPC_CSSEL    <= '0;
         SPC_TXDATA   <= '0;
      end else begin
         DONE <= 1'b0;
         if (SPC_SPISTART && SPC_SPIBUSY) SPC_SPISTART <= 1'b0;
         if (tx_pop) begin
            SPC_TXDATA <= tx_empty ? '0 : tx_head;
            tx_rem     <= tx_rem - 9'd1;
         end
         if (rx_evt) rx_rem <= rx_rem - 9'd1;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  tx_rem    <= wcnt_decode(WCNT);
                  rx_rem    <= wcnt_decode(WCNT);
                  SPC_CSSEL <= cs_onehot;
                  BUSY      <= 1'b1;
                  state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               SPC_SPISTART <= 1'b1;
               state        <= ST_EXEC;
            end
            ST_EXEC: begin
               if (SPC_SPIBUSY) state <= ST_TRANS;
            end
            ST_TRANS: begin
               if (((rx_rem == 9'd0) || stopped) && !SPC_SPIBUSY) state <= ST_END;
            end
            ST_END: begin
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky error flags; a new error outranks a simultaneous clear
   always_ff @(posedge SYSCLK) begin
      if (!SYSRSTB) begin
         TXUNDER <= 1'b0;
         RXOVER  <= 1'b0;
      end else begin
         if (tx_pop && tx_empty)    TXUNDER <= 1'b1;
         else if (ERRCLR)           TXUNDER <= 1'b0;
         if (rx_evt && rx_full)     RXOVER  <= 1'b1;
         else if (ERRCLR)           RXOVER  <= 1'b0;
      end
   end

   sc_spi_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (SYSCLK),
      .rstb  (SYSRSTB),
      .clr   (tx_flush),
      .push  (TXWE),
      .wdata (TXWDATA),
      .pop   (tx_pop),
      .rdata (tx_head),
      .empty (tx_empty),
      .full  (TXFULL),
      .level (TXLEVEL)
   );

   sc_spi_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (SYSCLK),
      .rstb  (SYSRSTB),
      .clr   (1'b0),
      .push  (rx_evt),
      .wdata (SPC_RXDATA),
      .pop   (RXRE),
      .rdata (RXRDATA),
      .empty (RXEMPTY),
      .full  (rx_full),
      .level (RXLEVEL)
   );

endmodule

// File: tb/tb_sc_spi_burst_ctrl.sv
// tb_sc_spi_burst_ctrl: randomized bench for sc_spi_burst_ctrl with an SPI
// engine model that echoes every consumed word back as received data.
module tb_sc_spi_burst_ctrl;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int NCS   = 4;
   localparam int CSW   = 2;
   localparam int LW    = 3;

   logic           clk = 1'b0;
   logic           rstb = 1'b0;
   logic           start = 1'b0;
   logic [7:0]     wcnt = '0;
   logic [CSW-1:0] cssel = '0;
   logic           txwe = 1'b0;
   logic [DW-1:0]  txwdata = '0;
   logic           txfull;
   logic [LW-1:0]  txlevel;
   logic           rxre = 1'b0;
   logic [DW-1:0]  rxrdata;
   logic           rxempty;
   logic [LW-1:0]  rxlevel;
   logic           busy, done, txunder, rxover;
   logic           errclr = 1'b0;
   logic           spc_spistart, spc_last;
   logic [NCS-1:0] spc_cssel;
   logic [DW-1:0]  spc_txdata;
   logic           spc_spibusy = 1'b0;
   logic           spc_txdetect = 1'b0;
   logic           spc_rxvalid = 1'b0;
   logic [DW-1:0]  spc_rxdata = '0;
   logic [2:0]     dbg_state;
`ifdef SC_SPI_BURST_ABORT_EN
   logic           abort = 1'b0;
`endif

   int vectors = 0;
   int miscompares = 0;

   // scoreboard: words expected in TX order, words the engine consumed, RX pops
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] eng_words[$];
   logic          eng_lasts[$];
   logic [DW-1:0] rx_popped_q[$];

   sc_spi_burst_ctrl #(.DW(DW), .DEPTH(DEPTH), .NCS(NCS)) dut (
      .SYSCLK(clk), .SYSRSTB(rstb), .START(start), .WCNT(wcnt), .CSSEL(cssel),
      .TXWE(txwe), .TXWDATA(txwdata), .TXFULL(txfull), .TXLEVEL(txlevel),
      .RXRE(rxre), .RXRDATA(rxrdata), .RXEMPTY(rxempty), .RXLEVEL(rxlevel),
      .BUSY(busy), .DONE(done), .TXUNDER(txunder), .RXOVER(rxover), .ERRCLR(errclr),
      .SPC_SPISTART(spc_spistart), .SPC_LAST(spc_last), .SPC_CSSEL(spc_cssel),
      .SPC_TXDATA(spc_txdata), .SPC_SPIBUSY(spc_spibusy), .SPC_TXDETECT(spc_txdetect),
      .SPC_RXVALID(spc_rxvalid), .SPC_RXDATA(spc_rxdata),
`ifdef SC_SPI_BURST_ABORT_EN
      .ABORT(abort),
`endif
      .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // SPI engine model: start on request, consume a word, return it, repeat
   // until a word is consumed while SPC_LAST is high, then drop busy.
   initial begin
      int phase = 0;
      int wcyc = 0;
      logic [DW-1:0] word = '0;
      logic last = 1'b0;
      forever begin
         @(negedge clk);
         spc_txdetect = 1'b0;
         spc_rxvalid  = 1'b0;
         if (!rstb) begin
            phase = 0;
            spc_spibusy = 1'b0;
         end else begin
            case (phase)
               0: if (spc_spistart) begin
                  spc_spibusy = 1'b1;
                  phase = 1;
                  wcyc = $urandom_range(1, 3);
               end
               1: if (wcyc > 1) wcyc--;
                  else begin
                     spc_txdetect = 1'b1;
                     word = spc_txdata;
                     last = spc_last;
                     eng_words.push_back(word);
                     eng_lasts.push_back(last);
                     phase = 2;
                     wcyc = $urandom_range(1, 3);
                  end
               2: if (wcyc > 1) wcyc--;
                  else begin
                     spc_rxvalid = 1'b1;
                     spc_rxdata = word;
                     if (last) phase = 3;
                     else begin
                        phase = 1;
                        wcyc = $urandom_range(1, 3);
                     end
                  end
               default: begin
                  spc_spibusy = 1'b0;
                  phase = 0;
               end
            endcase
         end
      end
   end

   // driver tasks
   task automatic push_tx(input logic [DW-1:0] d);
      @(negedge clk);
      txwe = 1'b1;
      txwdata = d;
      exp_q.push_back(d);
      @(negedge clk);
      txwe = 1'b0;
   endtask

   task automatic pop_rx(output logic [DW-1:0] d);
      @(negedge clk);
      d = rxrdata;
      rxre = 1'b1;
      @(negedge clk);
      rxre = 1'b0;
   endtask

   task automatic pulse_errclr();
      @(negedge clk);
      errclr = 1'b1;
      @(negedge clk);
      errclr = 1'b0;
   endtask

   task automatic drain_rx();
      logic [DW-1:0] d;
      for (int i = 0; i < 2 * DEPTH && !rxempty; i++) pop_rx(d);
   endtask

   // Start a burst and wait for DONE; optionally stream TX refills / RX drains
   task automatic run_burst(input int n_enc, input int cs, input bit stream_tx,
                            input int stream_total, input bit drain, input bit spurious,
                            output logic [NCS-1:0] cs_seen, output int dones,
                            output bit timed_out);
      int pushed;
      pushed = exp_q.size();
      eng_words.delete();
      eng_lasts.delete();
      @(negedge clk);
      start = 1'b1;
      wcnt = 8'(n_enc);
      cssel = CSW'(cs);
      @(negedge clk);
      start = 1'b0;
      cs_seen = spc_cssel;
      dones = 0;
      timed_out = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         start = 1'b0;
         txwe = 1'b0;
         rxre = 1'b0;
         if (done) begin
            dones++;
            timed_out = 1'b0;
            break;
         end
         if (spurious && c == 5 && busy) begin
            start = 1'b1;
            wcnt = 8'd7;
            cssel = CSW'(cs + 1);
         end
         if (stream_tx && !txfull && pushed < stream_total) begin
            txwe = 1'b1;
            txwdata = $urandom;
            exp_q.push_back(txwdata);
            pushed++;
         end
         if (drain && !rxempty) begin
            rx_popped_q.push_back(rxrdata);
            rxre = 1'b1;
         end
      end
      @(negedge clk);
      start = 1'b0;
      txwe = 1'b0;
      rxre = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) dones++;
      end
   endtask

   task automatic test_reset();
      rstb = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({txlevel, rxlevel, txfull, rxempty} !== {3'd0, 3'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_fifo: got %b want %b", {txlevel, rxlevel, txfull, rxempty}, 8'b00000001);
      end
      vectors++;
      if ({busy, done, txunder, rxover, spc_spistart, spc_last} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 000000", {busy, done, txunder, rxover, spc_spistart, spc_last});
      end
      vectors++;
      if ({spc_cssel, spc_txdata, rxrdata, dbg_state} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: cssel %b txdata %h rxrdata %h state %0d want all 0", spc_cssel, spc_txdata, rxrdata, dbg_state);
      end
      rstb = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [NCS-1:0] cs_seen;
      int dones;
      bit to;
      logic [DW-1:0] d;
      exp_q.delete();
      for (int i = 0; i < 4; i++) push_tx($urandom);
      run_burst(4, 2, 1'b0, 0, 1'b0, 1'b0, cs_seen, dones, to);
      vectors++;
      if (to || dones != 1) begin
         miscompares++;
         $display("FAIL basic_done: got %0d pulses (timeout %0d) want 1", dones, to);
      end
      vectors++;
      if (cs_seen !== 4'b0100) begin
         miscompares++;
         $display("FAIL basic_cssel: got %b want 0100", cs_seen);
      end
      vectors++;
      if (eng_words.size() != 4) begin
         miscompares++;
         $display("FAIL basic_loads: got %0d want 4", eng_words.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (eng_words[i] !== exp_q[i] || eng_lasts[i] !== (i == 3)) begin
               miscompares++;
               $display("FAIL basic_word%0d: got %h last %b want %h last %b", i, eng_words[i], eng_lasts[i], exp_q[i], (i == 3));
            end
         end
      end
      vectors++;
      if ({txunder, rxover, busy, rxlevel} !== {3'b000, 3'd4}) begin
         miscompares++;
         $display("FAIL basic_status: under %b over %b busy %b rxlevel %0d want 0 0 0 4", txunder, rxover, busy, rxlevel);
      end
      for (int i = 0; i < 4; i++) begin
         pop_rx(d);
         vectors++;
         if (d !== exp_q[i]) begin
            miscompares++;
            $display("FAIL basic_rx%0d: got %h want %h", i, d, exp_q[i]);
         end
      end
   endtask

   task automatic test_wcnt256();
      logic [NCS-1:0] cs_seen;
      int dones;
      bit to;
      int bad;
      exp_q.delete();
      rx_popped_q.delete();
      for (int i = 0; i < DEPTH; i++) push_tx($urandom);
      run_burst(0, 0, 1'b1, 256, 1'b1, 1'b0, cs_seen, dones, to);
      for (int i = 0; i < 2 * DEPTH && !rxempty; i++) begin
         @(negedge clk);
         rx_popped_q.push_back(rxrdata);
         rxre = 1'b1;
         @(negedge clk);
         rxre = 1'b0;
      end
      vectors++;
      if (to || dones != 1) begin
         miscompares++;
         $display("FAIL w256_done: got %0d pulses (timeout %0d) want 1", dones, to);
      end
      vectors++;
      if (eng_words.size() != 256 || rx_popped_q.size() != 256) begin
         miscompares++;
         $display("FAIL w256_count: loads %0d rx %0d want 256 256", eng_words.size(), rx_popped_q.size());
      end else begin
         bad = 0;
         for (int i = 0; i < 256; i++)
            if (eng_words[i] !== exp_q[i] || rx_popped_q[i] !== exp_q[i]) bad++;
         vectors++;
         if (bad != 0) begin
            miscompares++;
            $display("FAIL w256_data: got %0d bad words want 0", bad);
         end
      end
      vectors++;
      if ({txunder, rxover, txlevel} !== 5'b0) begin
         miscompares++;
         $display("FAIL w256_status: under %b over %b txlevel %0d want 0 0 0", txunder, rxover, txlevel);
      end
   endtask

   task automatic test_underrun();
      logic [NCS-1:0] cs_seen;
      int dones;
      bit to;
      logic [DW-1:0] d;
      exp_q.delete();
      push_tx($urandom);
      push_tx($urandom);
      exp_q.push_back('0);
      run_burst(3, 1, 1'b0, 0, 1'b0, 1'b0, cs_seen, dones, to);
      vectors++;
      if (to || eng_words.size() != 3) begin
         miscompares++;
         $display("FAIL under_loads: got %0d (timeout %0d) want 3", eng_words.size(), to);
      end else begin
         vectors++;
         if (eng_words[2] !== '0 || eng_words[0] !== exp_q[0] || eng_words[1] !== exp_q[1]) begin
            miscompares++;
            $display("FAIL under_data: got %h %h %h want %h %h 0", eng_words[0], eng_words[1], eng_words[2], exp_q[0], exp_q[1]);
         end
      end
      vectors++;
      if ({txunder, rxover} !== 2'b10) begin
         miscompares++;
         $display("FAIL under_flags: got %b want 10", {txunder, rxover});
      end
      for (int i = 0; i < 3; i++) begin
         pop_rx(d);
         vectors++;
         if (d !== exp_q[i]) begin
            miscompares++;
            $display("FAIL under_rx%0d: got %h want %h", i, d, exp_q[i]);
         end
      end
      pulse_errclr();
      vectors++;
      if (txunder !== 1'b0) begin
         miscompares++;
         $display("FAIL under_clear: got %b want 0", txunder);
      end
   endtask

   task automatic test_rx_overflow();
      logic [NCS-1:0] cs_seen;
      int dones;
      bit to;
      logic [DW-1:0] d;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) push_tx($urandom);
      run_burst(6, 3, 1'b1, 6, 1'b0, 1'b0, cs_seen, dones, to);
      vectors++;
      if (to || dones != 1 || eng_words.size() != 6) begin
         miscompares++;
         $display("FAIL over_done: pulses %0d loads %0d timeout %0d want 1 6 0", dones, eng_words.size(), to);
      end
      vectors++;
      if ({rxlevel, rxover, txunder} !== {3'd4, 2'b10}) begin
         miscompares++;
         $display("FAIL over_flags: rxlevel %0d over %b under %b want 4 1 0", rxlevel, rxover, txunder);
      end
      for (int i = 0; i < DEPTH; i++) begin
         pop_rx(d);
         vectors++;
         if (d !== exp_q[i]) begin
            miscompares++;
            $display("FAIL over_rx%0d: got %h want %h", i, d, exp_q[i]);
         end
      end
      pulse_errclr();
      vectors++;
      if (rxover !== 1'b0) begin
         miscompares++;
         $display("FAIL over_clear: got %b want 0", rxover);
      end
   endtask

   // Random bursts back to back, with a START injected mid-burst each time
   task automatic test_back_to_back();
      logic [NCS-1:0] cs_seen;
      int dones, n, p, cs, nrx;
      bit to;
      logic [DW-1:0] d, e;
      for (int k = 0; k < 6; k++) begin
         pulse_errclr();
         exp_q.delete();
         n = $urandom_range(1, 6);
         p = $urandom_range(0, (n < DEPTH) ? n : DEPTH);
         cs = $urandom_range(0, NCS - 1);
         for (int j = 0; j < p; j++) push_tx($urandom);
         run_burst(n, cs, 1'b0, 0, 1'b0, 1'b1, cs_seen, dones, to);
         vectors++;
         if (to || dones != 1 || cs_seen !== (4'b0001 << cs)) begin
            miscompares++;
            $display("FAIL b2b%0d_done: pulses %0d cs %b timeout %0d want 1 %b 0", k, dones, cs_seen, to, 4'b0001 << cs);
         end
         vectors++;
         if (eng_words.size() != n) begin
            miscompares++;
            $display("FAIL b2b%0d_loads: got %0d want %0d", k, eng_words.size(), n);
         end else begin
            for (int i = 0; i < n; i++) begin
               e = (i < p) ? exp_q[i] : '0;
               vectors++;
               if (eng_words[i] !== e) begin
                  miscompares++;
                  $display("FAIL b2b%0d_word%0d: got %h want %h", k, i, eng_words[i], e);
               end
            end
         end
         nrx = (n < DEPTH) ? n : DEPTH;
         vectors++;
         if ({txunder, rxover, rxlevel, txlevel} !== {(n > p), (n > DEPTH), 3'(nrx), 3'd0}) begin
            miscompares++;
            $display("FAIL b2b%0d_status: under %b over %b rxlevel %0d txlevel %0d want %b %b %0d 0", k, txunder, rxover, rxlevel, txlevel, n > p, n > DEPTH, nrx);
         end
         for (int i = 0; i < nrx; i++) begin
            pop_rx(d);
            e = (i < p) ? exp_q[i] : '0;
            vectors++;
            if (d !== e) begin
               miscompares++;
               $display("FAIL b2b%0d_rx%0d: got %h want %h", k, i, d, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit reached;
      int dones;
      exp_q.delete();
      eng_words.delete();
      for (int i = 0; i < 4; i++) push_tx($urandom);
      @(negedge clk);
      start = 1'b1;
      wcnt = 8'd4;
      @(negedge clk);
      start = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (dbg_state == 3'd3 && eng_words.size() >= 1) begin
            reached = 1'b1;
            break;
         end
      end
      vectors++;
      if (!reached) begin
         miscompares++;
         $display("FAIL rstmid_reach: got no TRANS want TRANS");
      end
      rstb = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, txlevel, rxempty, done, dbg_state} !== {1'b0, 3'd0, 1'b1, 1'b0, 3'd0}) begin
         miscompares++;
         $display("FAIL rstmid_state: busy %b txlevel %0d rxempty %b done %b state %0d want 0 0 1 0 0", busy, txlevel, rxempty, done, dbg_state);
      end
      @(negedge clk);
      rstb = 1'b1;
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) dones++;
      end
      vectors++;
      if (dones != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rstmid_nodone: got %0d pulses busy %b want 0 0", dones, busy);
      end
   endtask

`ifdef SC_SPI_BURST_ABORT_EN
   task automatic test_abort();
      int dones;
      bit to, seen2;
      logic last_seen;
      logic [DW-1:0] d;
      exp_q.delete();
      eng_words.delete();
      for (int i = 0; i < DEPTH; i++) push_tx($urandom);
      @(negedge clk);
      start = 1'b1;
      wcnt = 8'd8;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      to = 1'b1;
      seen2 = 1'b0;
      last_seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            to = 1'b0;
            break;
         end
         if (abort && busy && dbg_state == 3'd3) last_seen = spc_last;
         if (seen2) abort = 1'b1;
         if (eng_words.size() >= 2) seen2 = 1'b1;
      end
      abort = 1'b0;
      @(negedge clk);
      vectors++;
      if (to || dones != 1 || last_seen !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_done: pulses %0d last %b timeout %0d want 1 1 0", dones, last_seen, to);
      end
      vectors++;
      if (txlevel !== 3'd0 || rxlevel !== 3'(eng_words.size())) begin
         miscompares++;
         $display("FAIL abort_levels: txlevel %0d rxlevel %0d want 0 %0d", txlevel, rxlevel, eng_words.size());
      end
      for (int i = 0; i < 2; i++) begin
         pop_rx(d);
         vectors++;
         if (d !== exp_q[i]) begin
            miscompares++;
            $display("FAIL abort_rx%0d: got %h want %h", i, d, exp_q[i]);
         end
      end
      drain_rx();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_wcnt256();
      test_underrun();
      test_rx_overflow();
      test_back_to_back();
      test_reset_mid();
`ifdef SC_SPI_BURST_ABORT_EN
      test_abort();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
